prog_loader: RTL and testbench
==============================

# prog_loader

Hardware program loader and run supervisor for the 16-bit RISC core. Accepts a valid/ready stream of (address, instruction) words and writes each into core RAM through the core's `Ram_addr`/`Ram_data`/`WR_RAM_E` port while `E` is held low. After the last word it raises `E`, supervises execution until `done` or a programmable timeout, and logs every change of `out_data` into a FIFO. This puts the bench-side load/run/monitor sequence into synthesizable RTL, generalised in width, log depth and timeout.

## Interface
Parameters:
- `ADDR_W`, 16, RAM address width
- `DATA_W`, 16, instruction and `out_data` width
- `CNT_W`, 16, loaded-word counter width
- `TO_W`, 24, timeout counter width
- `LOG_DEPTH`, 8, `out_data` log FIFO depth; power of two, ≥2

Ports:
- `CLK`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ld_valid`  in  1  load word present
- `ld_ready`  out  1  loader can accept a word
- `ld_addr`  in  ADDR_W  RAM address of the word
- `ld_data`  in  DATA_W  instruction word
- `ld_last`  in  1  final word of the program
- `abort`  in  1  return to IDLE from any state
- `clear`  in  1  acknowledge FIN/TOUT, return to IDLE
- `timeout_cycles`  in  TO_W  run limit in cycles; 0 = no limit
- `Ram_addr`  out  ADDR_W  to core
- `Ram_data`  out  DATA_W  to core
- `WR_RAM_E`  out  1  to core, RAM write strobe
- `E`  out  1  to core, run enable
- `done`  in  1  from core
- `out_data`  in  DATA_W  from core
- `log_valid`  out  1  log FIFO not empty
- `log_ready`  in  1  log pop
- `log_data`  out  DATA_W  FIFO head
- `log_overflow`  out  1  sticky: a change was dropped because the FIFO was full
- `word_count`  out  CNT_W  words written since the last load start; saturating
- `busy`  out  1  state is WRITE or RUN
- `finished`  out  1  state is FIN
- `timed_out`  out  1  state is TOUT

## Operation
- States: IDLE, WRITE, RUN, FIN, TOUT.
- IDLE: `ld_ready`=1. On `ld_valid`:
  - register `ld_addr`/`ld_data` into `Ram_addr`/`Ram_data`, latch `ld_last`, go to WRITE.
  - If this is the first word since leaving FIN/TOUT/abort/reset, clear `word_count` before incrementing.
- WRITE: `WR_RAM_E`=1 for exactly one cycle, `ld_ready`=0, `word_count` += 1 (saturating at all-ones).
  - Latched last=1: go to RUN, clear the run counter.
  - Latched last=0: go back to IDLE.
- RUN: `E`=1, run counter += 1 each cycle.
  - `done`=1: go to FIN.
  - Else if `timeout_cycles`≠0 and counter == `timeout_cycles`−1: go to TOUT.
  - `done` and timeout in the same cycle: FIN wins.
- FIN/TOUT: `E`=0, wait for `clear`, then go to IDLE.
- `abort` has priority over everything. Next state is IDLE; `E` and `WR_RAM_E` drop on the next edge. The log FIFO and `log_overflow` are kept.
- `Ram_addr`/`Ram_data` hold their last value outside WRITE.
- Log:
  - `last_out` register, reset 0.
  - In RUN, when `out_data` ≠ `last_out`: push `out_data` and update `last_out`.
  - If the FIFO is full and not popping in the same cycle: drop the value, set `log_overflow`, but still update `last_out`.
  - Push and pop in the same cycle when full: both take effect.
  - Pop is allowed in any state.
  - `log_overflow` clears only on reset.

## Timing
- Reset values: all outputs 0 except `ld_ready`=1 (state IDLE). FIFO empty, `last_out`=0.
- Load throughput: one word per 2 cycles.
  - `ld_ready` is combinational from state.
  - `WR_RAM_E` is asserted in the cycle after acceptance, with `Ram_addr`/`Ram_data` already stable in that cycle.
- `E` rises on the edge after the WRITE cycle of the last word. Run counter is 0 in the first RUN cycle.
- With a limit T: TOUT is entered on the edge ending the T-th RUN cycle, and `E` falls on that same edge.
- `done` sampled in RUN: FIN is registered on the next edge, with `E`=0 on that edge.
- Log push is visible on `log_valid` on the edge after the change is sampled.
- `log_data` is the registered FIFO head.

## Structure
- `prog_loader_pkg`: state encodings and default parameter constants.
- Sub-module `pl_log_fifo`: synchronous FIFO, parameters DATA_W/DEPTH, with push/pop/full/empty/head; `prog_loader` contains one instance.
- Everything else (FSM, counters, change detect) lives in `prog_loader`.

## Test plan
- Load 3 words (0000:1111, 0001:2222, 0002:3333, last on third): `WR_RAM_E` pulses 3 times, 2 cycles apart, with matching addr/data; `word_count`=3; `E` rises 1 cycle after the third pulse.
- RUN with `timeout_cycles`=0; `done` raised after 50 cycles: `finished`=1 and `E`=0 next edge; `clear` returns to IDLE with `ld_ready`=1.
- `timeout_cycles`=10, `done` never asserted: `E` high for exactly 10 cycles, then `timed_out`=1.
- `out_data` sequence 0,5,5,7,0 during RUN: FIFO holds 5,7,0; the repeated 5 is not logged.
- LOG_DEPTH=8 with 9 changes and no pop: `log_overflow`=1 and FIFO holds the first 8. Repeat with a simultaneous push and pop while full: no loss.
- `abort` during WRITE and reset during RUN: IDLE next edge with `E`=0 and `WR_RAM_E`=0; after the async reset every output matches its reset value.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared state encoding and default sizing for the program loader.
package prog_loader_pkg;

    localparam int unsigned PL_ADDR_W    = 16;
    localparam int unsigned PL_DATA_W    = 16;
    localparam int unsigned PL_CNT_W     = 16;
    localparam int unsigned PL_TO_W      = 24;
    localparam int unsigned PL_LOG_DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIN   = 3'd3,
        ST_TOUT  = 3'd4
    } pl_state_e;

endpackage

// File: rtl/pl_log_fifo.sv
// Shift-register FIFO: slot 0 is always the head, so the head output is a flop.
module pl_log_fifo
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W = PL_DATA_W,
    parameter int unsigned DEPTH  = PL_LOG_DEPTH
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     count_q;
    logic              pop_en;
    logic              push_en;
    logic [AW-1:0]     wr_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    // A simultaneous pop shifts everything down, so the write lands one slot lower.
    assign wr_idx  = pop_en ? AW'(count_q - CW'(1)) : AW'(count_q);
    assign head    = mem[0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [DATA_W-1:0] slot_q;
        logic [DATA_W-1:0] shift_in;

        if (g < DEPTH - 1) begin : g_mid
            assign shift_in = mem[g+1];
        end else begin : g_end
            assign shift_in = slot_q;
        end

        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (push_en && (wr_idx == AW'(g))) begin
                slot_q <= din;
            end else if (pop_en) begin
                slot_q <= shift_in;
            end
        end

        assign mem[g] = slot_q;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a program into core RAM, runs it under a timeout and logs out_data changes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = PL_ADDR_W,
    parameter int unsigned DATA_W    = PL_DATA_W,
    parameter int unsigned CNT_W     = PL_CNT_W,
    parameter int unsigned TO_W      = PL_TO_W,
    parameter int unsigned LOG_DEPTH = PL_LOG_DEPTH
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              abort,
    input  logic              clear,
    input  logic [TO_W-1:0]   timeout_cycles,
    output logic [ADDR_W-1:0] Ram_addr,
    output logic [DATA_W-1:0] Ram_data,
    output logic              WR_RAM_E,
    output logic              E,
    input  logic              done,
    input  logic [DATA_W-1:0] out_data,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [DATA_W-1:0] log_data,
    output logic              log_overflow,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              finished,
    output logic              timed_out
);

    pl_state_e         state_q;
    pl_state_e         state_d;
    logic              last_q;
    logic              fresh_q;
    logic [TO_W-1:0]   run_cnt_q;
    logic [DATA_W-1:0] last_out_q;
    logic              ovf_q;
    logic              accept_c;
    logic              write_c;
    logic              to_hit_c;
    logic              log_push_c;
    logic              log_drop_c;
    logic              fifo_full;
    logic              fifo_empty;

    assign ld_ready     = (state_q == ST_IDLE);
    assign WR_RAM_E     = (state_q == ST_WRITE);
    assign E            = (state_q == ST_RUN);
    assign busy         = (state_q == ST_WRITE) || (state_q == ST_RUN);
    assign finished     = (state_q == ST_FIN);
    assign timed_out    = (state_q == ST_TOUT);
    assign log_valid    = !fifo_empty;
    assign log_overflow = ovf_q;

    assign to_hit_c   = (timeout_cycles != '0) && (run_cnt_q == timeout_cycles - TO_W'(1));
    assign log_push_c = (state_q == ST_RUN) && (out_data != last_out_q);
    assign log_drop_c = log_push_c && fifo_full && !log_ready;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        write_c  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ld_valid) begin
                        accept_c = 1'b1;
                        state_d  = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    write_c = 1'b1;
                    state_d = last_q ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (done) begin
                        state_d = ST_FIN;
                    end else if (to_hit_c) begin
                        state_d = ST_TOUT;
                    end
                end
                ST_FIN, ST_TOUT: begin
                    if (clear) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Load datapath, word counter and run counter.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Ram_addr   <= '0;
            Ram_data   <= '0;
            last_q     <= 1'b0;
            fresh_q    <= 1'b1;
            word_count <= '0;
            run_cnt_q  <= '0;
        end else begin
            if (accept_c) begin
                Ram_addr <= ld_addr;
                Ram_data <= ld_data;
                last_q   <= ld_last;
            end
            if (abort) begin
                fresh_q <= 1'b1;
            end else if (accept_c) begin
                fresh_q <= 1'b0;
            end else if ((state_q == ST_FIN || state_q == ST_TOUT) && clear) begin
                fresh_q <= 1'b1;
            end
            if (accept_c && fresh_q) begin
                word_count <= '0;
            end else if (write_c && (word_count != {CNT_W{1'b1}})) begin
                word_count <= word_count + CNT_W'(1);
            end
            if (write_c && last_q) begin
                run_cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                run_cnt_q <= run_cnt_q + TO_W'(1);
            end
        end
    end

    // Change detector; last_out tracks even values the full FIFO drops.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            last_out_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (log_push_c) begin
                last_out_q <= out_data;
            end
            if (log_drop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    pl_log_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (LOG_DEPTH)
    ) u_log_fifo (
        .CLK   (CLK),
        .rst_n (rst_n),
        .push  (log_push_c),
        .pop   (log_ready),
        .din   (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (log_data)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized checks of prog_loader against a transaction-level model.
module tb_prog_loader;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 24;
    localparam int unsigned LD = 8;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          abort = 1'b0;
    logic          clear = 1'b0;
    logic [TW-1:0] timeout_cycles = '0;
    logic [AW-1:0] Ram_addr;
    logic [DW-1:0] Ram_data;
    logic          WR_RAM_E;
    logic          E;
    logic          done = 1'b0;
    logic [DW-1:0] out_data = '0;
    logic          log_valid;
    logic          log_ready = 1'b0;
    logic [DW-1:0] log_data;
    logic          log_overflow;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          finished;
    logic          timed_out;

    always #5 CLK = ~CLK;

    prog_loader dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .abort          (abort),
        .clear          (clear),
        .timeout_cycles (timeout_cycles),
        .Ram_addr       (Ram_addr),
        .Ram_data       (Ram_data),
        .WR_RAM_E       (WR_RAM_E),
        .E              (E),
        .done           (done),
        .out_data       (out_data),
        .log_valid      (log_valid),
        .log_ready      (log_ready),
        .log_data       (log_data),
        .log_overflow   (log_overflow),
        .word_count     (word_count),
        .busy           (busy),
        .finished       (finished),
        .timed_out      (timed_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: expected log contents, last seen value, sticky overflow.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last = '0;
    bit            m_ovf = 1'b0;

    // Stimulus tables.
    logic [AW-1:0] prog_a[$];
    logic [DW-1:0] prog_d[$];
    logic [DW-1:0] seq[$];
    bit            popq[$];

    // Observed RAM writes.
    logic [AW+DW-1:0] wrq[$];
    always @(negedge CLK) begin
        if (WR_RAM_E === 1'b1) wrq.push_back({Ram_addr, Ram_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "ld_ready"}, ld_ready, 1);
        chk({p, "E"}, E, 0);
        chk({p, "WR_RAM_E"}, WR_RAM_E, 0);
        chk({p, "busy"}, busy, 0);
        chk({p, "finished"}, finished, 0);
        chk({p, "timed_out"}, timed_out, 0);
        chk({p, "log_valid"}, log_valid, 0);
        chk({p, "log_overflow"}, log_overflow, 0);
        chk({p, "word_count"}, word_count, 0);
        chk({p, "Ram_addr"}, Ram_addr, 0);
        chk({p, "Ram_data"}, Ram_data, 0);
        chk({p, "log_data"}, log_data, 0);
    endtask

    // Feed prog_a/prog_d; the last entry carries ld_last. Ends in the first RUN cycle.
    task automatic load_prog();
        int n;
        n = prog_a.size();
        wrq.delete();
        for (int k = 0; k < n; k++) begin
            ld_addr  = prog_a[k];
            ld_data  = prog_d[k];
            ld_last  = (k == n - 1);
            ld_valid = 1'b1;
            step();
            ld_valid = 1'b0;
            chk("wr_strobe", WR_RAM_E, 1);
            chk("ld_ready_in_write", ld_ready, 0);
            chk("E_low_in_write", E, 0);
            step();
            chk("strobe_one_cycle", WR_RAM_E, 0);
            chk("word_count", word_count, k + 1);
        end
        ld_last = 1'b0;
        chk("E_rise", E, 1);
        chk("busy_run", busy, 1);
        chk("wr_pulses", wrq.size(), n);
        for (int k = 0; k < n && k < wrq.size(); k++) begin
            chk("wr_addr_data", wrq[k], {prog_a[k], prog_d[k]});
        end
    endtask

    // Drive out_data from seq (then hold) and pops from popq (then none) while E is high.
    task automatic run_prog(input int done_at, input int t_lim);
        int  exp_len;
        bit  exp_fin;
        int  c;
        logic [DW-1:0] v;
        bit  p;
        timeout_cycles = TW'(t_lim);
        exp_fin = (t_lim == 0) || (done_at < t_lim);
        exp_len = exp_fin ? done_at + 1 : t_lim;
        c = 0;
        while (E === 1'b1 && c < exp_len + 5) begin
            chk("log_valid_run", log_valid, mq.size() != 0);
            if (mq.size() != 0) chk("log_head_run", log_data, mq[0]);
            v = (seq.size() != 0) ? seq.pop_front() : out_data;
            p = (popq.size() != 0) ? popq.pop_front() : 1'b0;
            out_data  = v;
            log_ready = p;
            done      = (c == done_at);
            if (p && mq.size() != 0) void'(mq.pop_front());
            if (v != m_last) begin
                if (mq.size() < LD) mq.push_back(v);
                else m_ovf = 1'b1;
                m_last = v;
            end
            step();
            c++;
        end
        done      = 1'b0;
        log_ready = 1'b0;
        chk("run_len", c, exp_len);
        chk("finished", finished, exp_fin);
        chk("timed_out", timed_out, !exp_fin);
        chk("E_fall", E, 0);
        chk("busy_end", busy, 0);
        chk("overflow", log_overflow, m_ovf);
        step();
        chk("hold_end_state", finished, exp_fin);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_ready", ld_ready, 1);
        chk("clear_fin", finished, 0);
        chk("clear_tout", timed_out, 0);
    endtask

    task automatic drain();
        int n;
        n = mq.size();
        log_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk("drain_valid", log_valid, 1);
            chk("drain_data", log_data, mq.pop_front());
            step();
        end
        log_ready = 1'b0;
        chk("drain_empty", log_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk_reset_vals("rst_");
        rst_n = 1'b1;
        step();

        // Three-word program, run until done after 50 cycles, log 0,5,5,7,0.
        prog_a = '{16'h0000, 16'h0001, 16'h0002};
        prog_d = '{16'h1111, 16'h2222, 16'h3333};
        load_prog();
        chk("word_count_3", word_count, 3);
        seq = '{16'd0, 16'd5, 16'd5, 16'd7, 16'd0};
        popq.delete();
        run_prog(50, 0);
        drain();

        // Timeout of 10 with done never raised.
        prog_a = '{16'h0040};
        prog_d = '{16'hBEEF};
        load_prog();
        seq.delete();
        run_prog(1000, 10);

        // Fill the log, then push and pop together while full: nothing lost.
        prog_a = '{16'h0100, 16'h0101};
        prog_d = '{16'hA000, 16'hA001};
        load_prog();
        seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        popq = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        run_prog(9, 0);
        chk("no_overflow_simul", log_overflow, 0);
        drain();

        // Nine changes without popping: first eight kept, overflow sticks.
        prog_a = '{16'h0200};
        prog_d = '{16'hC0DE};
        load_prog();
        seq = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18, 16'd19};
        popq.delete();
        run_prog(9, 0);
        chk("overflow_set", log_overflow, 1);
        drain();

        // Abort while the write strobe is up.
        ld_addr  = 16'h0300;
        ld_data  = 16'h5A5A;
        ld_last  = 1'b1;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("abort_pre_strobe", WR_RAM_E, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_strobe", WR_RAM_E, 0);
        chk("abort_E", E, 0);
        chk("abort_ready", ld_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_keeps_ovf", log_overflow, 1);
        step();
        chk("abort_no_run", E, 0);

        // Randomized programs, run limits, out_data streams and pops.
        for (int it = 0; it < 5; it++) begin
            int n;
            int t_lim;
            n = $urandom_range(1, 4);
            prog_a.delete();
            prog_d.delete();
            for (int k = 0; k < n; k++) begin
                prog_a.push_back(AW'($urandom));
                prog_d.push_back(DW'($urandom));
            end
            load_prog();
            seq.delete();
            popq.delete();
            for (int k = 0; k < 45; k++) begin
                seq.push_back(DW'($urandom_range(0, 3)));
                popq.push_back($urandom_range(0, 99) < 30);
            end
            t_lim = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
            run_prog(int'($urandom_range(0, 40)), t_lim);
            drain();
        end

        // Asynchronous reset in the middle of a run.
        prog_a = '{16'h0400};
        prog_d = '{16'h7777};
        load_prog();
        timeout_cycles = '0;
        out_data = 16'h00AA;
        step();
        step();
        chk("pre_reset_E", E, 1);
        chk("pre_reset_log", log_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst_");
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        out_data = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_ready", ld_ready, 1);
        chk("post_reset_E", E, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
